// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_div(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(input mdu_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input mdu_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One radix-2 iteration: shift-add for multiply, compare-subtract-shift for
// restoring divide. The guard bit of the partial remainder lives in 'shifted'.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         div_mode,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] opnd,
    output logic [W-1:0] hi_next,
    output logic [W-1:0] lo_next
);

    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         ge;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[W-1]};
        ge      = shifted >= {1'b0, opnd};
        // when ge holds the true difference is below opnd, so W bits suffice
        diff    = shifted[W-1:0] - opnd;
        if (div_mode) begin
            hi_next = ge ? diff : shifted[W-1:0];
            lo_next = {lo[W-2:0], ge};
        end else begin
            hi_next = sum[W:1];
            lo_next = {sum[0], lo[W-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Optional MDU_EARLY_OUT_EN: divide-by-zero / signed overflow finish at accept.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready = 1
// CALC  | W radix-2 iterations on hi/lo
// FIX   | sign correction, special values, result registered
// DONE  | result held, out_valid = 1 until out_ready
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    MDUResult
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    mdu_state_e     state;
    logic [CW-1:0]  count;
    mdu_op_e        op_q;
    logic           sign_a;
    logic           sign_b;
    logic           special;
    logic [W-1:0]   special_res;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic [W-1:0]   opnd;
    logic [W-1:0]   hi_next;
    logic [W-1:0]   lo_next;

    mdu_op_e        op_in;
    logic [W-1:0]   abs_a;
    logic [W-1:0]   abs_b;
    logic           b_zero;
    logic           ovf;
    logic           special_in;
    logic [W-1:0]   forced_in;

    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot;
    logic [W-1:0]   rem;
    logic [W-1:0]   fix_res;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        op_in      = mdu_op_e'(Operation);
        abs_a      = (is_signed_a(op_in) && SrcA[W-1]) ? -SrcA : SrcA;
        abs_b      = (is_signed_b(op_in) && SrcB[W-1]) ? -SrcB : SrcB;
        b_zero     = (SrcB == '0);
        ovf        = (op_in == OP_DIV || op_in == OP_REM) && (SrcA == MIN_VAL) && (SrcB == '1);
        special_in = is_div(op_in) && (b_zero || ovf);
        if (b_zero)
            forced_in = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : SrcA;
        else if (op_in == OP_DIV)
            forced_in = MIN_VAL;
        else
            forced_in = '0;
    end

    mdu_iter_step #(.W(W)) u_step (
        .div_mode (is_div(op_q)),
        .hi       (hi),
        .lo       (lo),
        .opnd     (opnd),
        .hi_next  (hi_next),
        .lo_next  (lo_next)
    );

    // product sits in {hi, lo}; divide leaves quotient in lo, remainder in hi
    always_comb begin
        prod   = {hi, lo};
        prod_s = (sign_a ^ sign_b) ? -prod : prod;
        quot   = (sign_a ^ sign_b) ? -lo : lo;
        rem    = sign_a ? -hi : hi;
        fix_res = '0;
        case (op_q)
            OP_MUL:                       fix_res = prod_s[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*W-1:W];
            OP_DIV, OP_DIVU:              fix_res = quot;
            OP_REM, OP_REMU:              fix_res = rem;
            default:                      fix_res = '0;
        endcase
        if (special)
            fix_res = special_res;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            MDUResult   <= '0;
            op_q        <= OP_MUL;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            special     <= 1'b0;
            special_res <= '0;
            hi          <= '0;
            lo          <= '0;
            opnd        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q        <= op_in;
                        sign_a      <= is_signed_a(op_in) & SrcA[W-1];
                        sign_b      <= is_signed_b(op_in) & SrcB[W-1];
                        special     <= special_in;
                        special_res <= forced_in;
                        hi          <= '0;
                        lo          <= is_div(op_in) ? abs_a : abs_b;
                        opnd        <= is_div(op_in) ? abs_b : abs_a;
                        count       <= '0;
`ifdef MDU_EARLY_OUT_EN
                        if (special_in) begin
                            MDUResult <= forced_in;
                            state     <= ST_DONE;
                        end else begin
                            state     <= ST_CALC;
                        end
`else
                        state       <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    hi    <= hi_next;
                    lo    <= lo_next;
                    count <= count + 1'b1;
                    if (count == CW'(W - 1)) begin
                        count <= '0;
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    MDUResult <= fix_res;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, hold/reset sequences
// and randomized operations against an arithmetic reference model.
module tb_mdu_iter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic [2:0]    Operation;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  MDUResult;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    mdu_iter #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .MDUResult (MDUResult)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Plain 64-bit arithmetic per RV32M rules.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Edges from the accept edge until out_valid is visible.
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = W + 1;
`ifdef MDU_EARLY_OUT_EN
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            lat = 0;
`else
        if (op[2] && a == 32'h1234_5678 && b == 32'h0) lat = W + 1;
`endif
        return lat;
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int hold);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        check({name, " in_ready before issue"}, 32'(in_ready), 32'd1);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        SrcA      = $urandom;
        SrcB      = $urandom;
        Operation = 3'($urandom_range(0, 7));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
        check({name, " result"}, MDUResult, exp);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid  = 1'b1;
                Operation = 3'd0;
                SrcA      = $urandom;
                SrcB      = $urandom;
                @(posedge clk); #1;
                check({name, " hold result"}, MDUResult, exp);
                check({name, " hold in_ready"}, 32'(in_ready), 32'd0);
                check({name, " hold out_valid"}, 32'(out_valid), 32'd1);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({name, " back to idle"}, 32'(in_ready), 32'd1);
        check({name, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        SrcA = '0; SrcB = '0; Operation = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", MDUResult, 32'd0);
        reset = 1'b0;
        check("reset in_ready", 32'(in_ready), 32'd1);

        vecs.push_back('{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3"});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min"});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max"});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "MULHSU -1*2"});
        vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, "MULH -1*5"});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "DIV -7/2"});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "REM -7/2"});
        vecs.push_back('{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "DIV 7/-2"});
        vecs.push_back('{3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, "REM 7/-2"});
        vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        "DIVU 100/7"});
        vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         "REMU 100/7"});
        vecs.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, "DIVU 5/0"});
        vecs.push_back('{3'd6, 32'd5,         32'd0,         32'd5,         "REM 5/0"});
        vecs.push_back('{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, "DIV -5/0"});
        vecs.push_back('{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "REM -5/0"});
        vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV min/-1"});
        vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "REM min/-1"});

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

        run_op("DIVU hold", 3'd5, 32'd100, 32'd7, 32'd14, 10);

        // abort a multiply mid-CALC; MDUResult still holds 14 until reset
        Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre-reset result held", MDUResult, 32'd14);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset result", MDUResult, 32'd0);
        check("mid reset in_ready", 32'(in_ready), 32'd1);
        run_op("MUL 3*4 after reset", 3'd0, 32'd3, 32'd4, 32'd12, 0);

        for (int n = 0; n < 150; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rand%0d op%0d %h %h", n, rop, ra, rb), rop, ra, rb,
                   ref_model(rop, ra, rb), (n % 37 == 5) ? 3 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
